// File: rtl/move_pin_encoder.sv
// move_pin_encoder: transmit side of the 8-bit pins move interface.
// A (row, col) move arrives over valid/ready and is sent as a row code
// phase, then a column code phase, then an idle gap. The encoder then waits
// for the game's echoed row/col to confirm delivery, re-sending on timeout
// up to MAX_RETRY times before giving up.
module move_pin_encoder #(
  parameter int unsigned ROW_HOLD    = 2,
  parameter int unsigned COL_HOLD    = 2,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [7:0]  IDLE_CODE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [2:0] mv_row,
  input  logic [2:0] mv_col,
  output logic [7:0] pins,
  input  logic [2:0] echo_row,
  input  logic [2:0] echo_col,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned MAX_AB = (ROW_HOLD > COL_HOLD) ? ROW_HOLD : COL_HOLD;
  localparam int unsigned MAX_CD = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int unsigned MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = (MAXP < 2) ? 1 : $clog2(MAXP);
  localparam int unsigned RW     = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] ROW_LAST  = CW'(ROW_HOLD - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COL_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TMO_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_GAP,
    S_WAIT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] retry_q;
  logic [2:0]    req_row_q, req_col_q;
  logic [2:0]    snap_row_q, snap_col_q;
  logic [7:0]    pins_q;
  logic          ready_q, busy_q, done_q, err_q;
  logic [1:0]    code_q;

  logic illegal_d, dup_d, ack_d;

  // Index k -> pin pattern: 1 maps to all-zero, 2..7 to a one-hot bit.
  function automatic logic [7:0] code_of(input logic [2:0] k);
    logic [7:0] c;
    if (k == 3'd1) c = '0;
    else           c = 8'h01 << (k - 3'd2);
    return c;
  endfunction

  // Acceptance screening and delivery acknowledgement.
  always_comb begin
    illegal_d = (mv_row == 3'd0) || (mv_row == 3'd7) || (mv_col == 3'd0);
    dup_d     = (echo_row == mv_row) && (echo_col == mv_col);
    ack_d     = (echo_row == req_row_q) && (echo_col == req_col_q) &&
                ({echo_row, echo_col} != {snap_row_q, snap_col_q});
  end

  // Move FSM with registered outputs; an early ack in any busy state completes the move.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      req_row_q  <= '0;
      req_col_q  <= '0;
      snap_row_q <= '0;
      snap_col_q <= '0;
      pins_q     <= IDLE_CODE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == S_IDLE) begin
        if (mv_valid && ready_q) begin
          if (illegal_d) begin
            err_q  <= 1'b1;
            code_q <= 2'b01;
          end else if (dup_d) begin
            err_q  <= 1'b1;
            code_q <= 2'b10;
          end else begin
            req_row_q  <= mv_row;
            req_col_q  <= mv_col;
            snap_row_q <= echo_row;
            snap_col_q <= echo_col;
            state_q    <= S_ROW;
            cnt_q      <= '0;
            retry_q    <= '0;
            pins_q     <= code_of(mv_row);
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
      end else if (ack_d) begin
        state_q <= S_IDLE;
        pins_q  <= IDLE_CODE;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        case (state_q)
          S_ROW: begin
            if (cnt_q == ROW_LAST) begin
              state_q <= S_COL;
              cnt_q   <= '0;
              pins_q  <= code_of(req_col_q);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_COL: begin
            if (cnt_q == COL_LAST) begin
              state_q <= (GAP_CYCLES == 0) ? S_WAIT : S_GAP;
              cnt_q   <= '0;
              pins_q  <= IDLE_CODE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_GAP: begin
            if (cnt_q == GAP_LAST) begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_WAIT: begin
            if (cnt_q == TMO_LAST) begin
              cnt_q <= '0;
              if (retry_q < RETRY_MAX) begin
                retry_q <= retry_q + RW'(1);
                state_q <= S_ROW;
                pins_q  <= code_of(req_row_q);
              end else begin
                state_q <= S_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                code_q  <= 2'b11;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            pins_q  <= IDLE_CODE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mv_ready = ready_q;
  assign pins     = pins_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_move_pin_encoder.sv
// Testbench for move_pin_encoder: directed moves plus random moves, each
// checked cycle by cycle against an expected trace built from the move rules.
module tb_move_pin_encoder;

  localparam int RH = 2;
  localparam int CH = 2;
  localparam int GC = 1;
  localparam int TO = 16;
  localparam int MR = 2;
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       mv_valid;
  logic       mv_ready;
  logic [2:0] mv_row, mv_col;
  logic [7:0] pins;
  logic [2:0] echo_row, echo_col;
  logic       busy, done, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  move_pin_encoder #(
    .ROW_HOLD   (RH),
    .COL_HOLD   (CH),
    .GAP_CYCLES (GC),
    .ACK_TIMEOUT(TO),
    .MAX_RETRY  (MR),
    .IDLE_CODE  (IDLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mv_valid(mv_valid),
    .mv_ready(mv_ready),
    .mv_row  (mv_row),
    .mv_col  (mv_col),
    .pins    (pins),
    .echo_row(echo_row),
    .echo_col(echo_col),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_code(err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected observation for one cycle after acceptance.
  typedef struct packed {
    logic [7:0] pins;
    logic       busy;
    logic       done;
    logic       err;
    logic       ready;
    logic [1:0] code;
  } exp_t;

  exp_t plan[$];

  function automatic logic [7:0] code_map(input int k);
    int v;
    v = (k == 1) ? 0 : (1 << (k - 2));
    return 8'(v);
  endfunction

  function automatic void push(input logic [7:0] p, input logic b, input logic d,
                               input logic e, input logic rd, input logic [1:0] cd);
    exp_t x;
    x.pins = p; x.busy = b; x.done = d; x.err = e; x.ready = rd; x.code = cd;
    plan.push_back(x);
  endfunction

  // Echo seen by the DUT during cycle n after acceptance.
  function automatic logic [5:0] echo_at(input int n, input int ack_at,
                                         input logic [5:0] req, input logic [5:0] snap);
    return (ack_at >= 0 && n >= ack_at) ? req : snap;
  endfunction

  // Expected trace: attempts of row/col/idle phases until echo confirms,
  // retries are exhausted, or the move is rejected outright.
  task automatic build_plan(input int r, input int c, input int sr, input int sc, input int ack_at);
    int att, total, k;
    logic [7:0] p;
    logic [5:0] req, snap, e;
    plan.delete();
    req  = {3'(r), 3'(c)};
    snap = {3'(sr), 3'(sc)};
    if (r == 0 || r == 7 || c == 0) begin
      push(IDLE, 0, 0, 1, 1, 2'b01);
      push(IDLE, 0, 0, 0, 1, 2'b00);
      return;
    end
    if (req == snap) begin
      push(IDLE, 0, 0, 1, 1, 2'b10);
      push(IDLE, 0, 0, 0, 1, 2'b00);
      return;
    end
    att   = RH + CH + GC + TO;
    total = (MR + 1) * att;
    for (int n = 0; n < total; n++) begin
      k = n % att;
      if (k < RH)           p = code_map(r);
      else if (k < RH + CH) p = code_map(c);
      else                  p = IDLE;
      push(p, 1, 0, 0, 0, 2'b00);
      e = echo_at(n, ack_at, req, snap);
      if (e == req && e != snap) begin
        push(IDLE, 0, 1, 0, 1, 2'b00);
        push(IDLE, 0, 0, 0, 1, 2'b00);
        return;
      end
    end
    push(IDLE, 0, 0, 1, 1, 2'b11);
    push(IDLE, 0, 0, 0, 1, 2'b00);
  endtask

  task automatic run_move(input string tag, input int r, input int c,
                          input int sr, input int sc, input int ack_at);
    build_plan(r, c, sr, sc, ack_at);
    @(negedge clk);
    check($sformatf("%s/ready_pre", tag), 32'(mv_ready), 32'd1);
    mv_row   = 3'(r);
    mv_col   = 3'(c);
    mv_valid = 1'b1;
    echo_row = 3'(sr);
    echo_col = 3'(sc);
    @(posedge clk); #1;
    for (int n = 0; n < plan.size(); n++) begin
      // Garbage on the request side while busy must be ignored.
      if (plan[n].busy) begin
        mv_valid = 1'($urandom_range(0, 1));
        mv_row   = 3'($urandom);
        mv_col   = 3'($urandom);
      end else begin
        mv_valid = 1'b0;
      end
      {echo_row, echo_col} = echo_at(n, ack_at, {3'(r), 3'(c)}, {3'(sr), 3'(sc)});
      @(negedge clk);
      check($sformatf("%s/pins@%0d", tag, n),  32'(pins),     32'(plan[n].pins));
      check($sformatf("%s/busy@%0d", tag, n),  32'(busy),     32'(plan[n].busy));
      check($sformatf("%s/done@%0d", tag, n),  32'(done),     32'(plan[n].done));
      check($sformatf("%s/err@%0d", tag, n),   32'(err),      32'(plan[n].err));
      check($sformatf("%s/ready@%0d", tag, n), 32'(mv_ready), 32'(plan[n].ready));
      if (plan[n].err)
        check($sformatf("%s/code@%0d", tag, n), 32'(err_code), 32'(plan[n].code));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int r, c, sr, sc, ack;
    rst = 1'b1; mv_valid = 1'b0; mv_row = '0; mv_col = '0;
    echo_row = '0; echo_col = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/pins",  32'(pins),     32'hFF);
    check("rst/ready", 32'(mv_ready), 32'd1);
    check("rst/busy",  32'(busy),     32'd0);
    check("rst/done",  32'(done),     32'd0);
    check("rst/err",   32'(err),      32'd0);
    check("rst/code",  32'(err_code), 32'd0);
    rst = 1'b0;

    // Directed moves
    run_move("m35",     3, 5, 0, 0, 7);
    run_move("m11",     1, 1, 0, 0, 5);
    run_move("ill04",   0, 4, 2, 3, -1);
    run_move("ill20",   2, 0, 2, 3, -1);
    run_move("ill74",   7, 4, 0, 0, -1);
    run_move("dup44",   4, 4, 4, 4, -1);
    run_move("timeout", 2, 6, 1, 1, -1);
    run_move("early",   6, 7, 3, 3, 1);
    run_move("lastack", 5, 2, 0, 0, 62);
    run_move("retry2",  4, 3, 0, 0, 30);

    // Reset during the column phase
    @(negedge clk);
    mv_row = 3'd3; mv_col = 3'd5; mv_valid = 1'b1; echo_row = '0; echo_col = '0;
    @(posedge clk); #1;
    mv_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstcol/pins_col", 32'(pins), 32'h08);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    echo_row = 3'd3; echo_col = 3'd5;
    check("rstcol/pins",  32'(pins),     32'hFF);
    check("rstcol/busy",  32'(busy),     32'd0);
    check("rstcol/ready", 32'(mv_ready), 32'd1);
    check("rstcol/done",  32'(done),     32'd0);
    check("rstcol/err",   32'(err),      32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rstcol/quiet_done@%0d", i), 32'(done), 32'd0);
      check($sformatf("rstcol/quiet_err@%0d", i),  32'(err),  32'd0);
    end
    run_move("after_rst", 2, 2, 3, 5, 6);

    // Random moves
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        sr = r; sc = c;
      end else begin
        sr = int'($urandom_range(0, 7));
        sc = int'($urandom_range(0, 7));
      end
      ack = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
      run_move($sformatf("rnd%0d", i), r, c, sr, sc, ack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
